// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
// FSM state encodings and the default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder, purely combinational.
// Ports: a, b, c in; sum, carry out.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  logic p;

  assign p     = a ^ b;
  assign sum   = p ^ c;
  assign carry = (a & b) | (c & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, carry FF, LSB first.
// Ports: clk, rst_n, start, a, b, cin in; busy, done, sum, cout out.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Holds the WIDTH-1 bits already produced; the final bit joins on the
  // last edge so the partial result never reaches sum.
  logic [WIDTH-2:0] sum_sh;
  logic             carry;
  logic             cell_sum;
  logic             cell_carry;
  logic [WIDTH-1:0] sum_nxt;
  logic             last;

  full_adder_cell u_cell (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c     (carry),
    .sum   (cell_sum),
    .carry (cell_carry)
  );

  assign sum_nxt = {cell_sum, sum_sh};
  assign last    = (cnt == CNT_W'(WIDTH - 1));
  assign busy    = (state == S_SHIFT);
  assign done    = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= S_SHIFT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SHIFT: begin
          sum_sh <= sum_nxt[WIDTH-1:1];
          carry  <= cell_carry;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (last) begin
            sum   <= sum_nxt;
            cout  <= cell_carry;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 and WIDTH=4.
// Scoreboard queues hold expected {cout,sum} until done is seen.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  int errors = 0;
  int checks = 0;

  logic [8:0] q8[$];
  logic [4:0] q4[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge right after the accepting edge.
  task automatic wait_done8(output int n, output int nb,
                            output bit moved);
    logic [7:0] s0;
    s0 = sum8;
    n = 0;
    nb = 0;
    moved = 1'b0;
    while (!done8 && n < 64) begin
      if (busy8) nb++;
      if (sum8 !== s0) moved = 1'b1;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pop_cmp8(input string tag);
    logic [8:0] e;
    e = (q8.size() > 0) ? q8.pop_front() : 9'h1ff;
    chk(tag, 32'({cout8, sum8}), 32'(e));
  endtask

  task automatic op8(input string tag, input logic [7:0] a,
                     input logic [7:0] b, input logic ci);
    int n, nb;
    bit moved;
    @(negedge clk);
    a8 = a;
    b8 = b;
    cin8 = ci;
    start8 = 1'b1;
    q8.push_back({1'b0, a} + {1'b0, b} + 9'(ci));
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(n, nb, moved);
    chk({tag, "_lat"}, 32'(n), 32'd8);
    chk({tag, "_busy"}, 32'(nb), 32'd8);
    chk({tag, "_hold"}, 32'(moved), 32'd0);
    pop_cmp8({tag, "_res"});
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done8), 32'd0);
  endtask

  initial begin
    int n, nb, nd;
    bit moved;
    logic [4:0] e4;

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_sum", 32'(sum8), 32'd0);
    chk("rst_cout", 32'(cout8), 32'd0);
    rst_n = 1'b1;

    op8("t1", 8'h5a, 8'h3c, 1'b0);
    op8("t2a", 8'hff, 8'h01, 1'b0);
    op8("t2b", 8'hff, 8'h00, 1'b1);

    // start during SHIFT must be ignored
    @(negedge clk);
    a8 = 8'h0f; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h010);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(n, nb, moved);
    chk("t3_lat", 32'(n), 32'd4);
    pop_cmp8("t3_res");
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) nd++;
    end
    chk("t3_ndone", 32'(nd), 32'd0);
    chk("t3_sum", 32'(sum8), 32'h10);

    // async reset mid-operation
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h44; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_busy", 32'(busy8), 32'd0);
    chk("t4_done", 32'(done8), 32'd0);
    chk("t4_sum", 32'(sum8), 32'd0);
    chk("t4_cout", 32'(cout8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op8("t4_after", 8'h21, 8'h12, 1'b1);

    // start held high across DONE
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h003);
    @(negedge clk);
    wait_done8(n, nb, moved);
    chk("t5_lat1", 32'(n), 32'd8);
    a8 = 8'h80; b8 = 8'h80;
    q8.push_back(9'h100);
    pop_cmp8("t5_res1");
    @(negedge clk);
    chk("t5_busy", 32'(busy8), 32'd1);
    chk("t5_pulse", 32'(done8), 32'd0);
    start8 = 1'b0;
    wait_done8(n, nb, moved);
    chk("t5_space", 32'(n + 1), 32'd9);
    pop_cmp8("t5_res2");
    @(negedge clk);
    chk("t5_end", 32'(done8), 32'd0);

    // WIDTH=4 exhaustive
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      a4 = i[3:0];
      b4 = i[7:4];
      cin4 = i[8];
      start4 = 1'b1;
      q4.push_back(5'(i[3:0]) + 5'(i[7:4]) + 5'(i[8]));
      @(negedge clk);
      start4 = 1'b0;
      n = 0;
      while (!done4 && n < 32) begin
        @(negedge clk);
        n++;
      end
      chk("w4_lat", 32'(n), 32'd4);
      e4 = (q4.size() > 0) ? q4.pop_front() : 5'h1f;
      chk("w4_res", 32'({cout4, sum4}), 32'(e4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
